// File: rtl/fp16_u8_pkg.sv
// Shared fp16 types, constants and the fp16 -> u8 conversion function
// used by the arbitrated converter datapath.
package fp16_u8_pkg;

  localparam int FP16_EXP_W  = 5;
  localparam int FP16_FRAC_W = 10;
  localparam int FP16_BIAS   = 15;
  localparam logic [7:0] U8_MAX = 8'hFF;

  typedef struct packed {
    logic                   sign;
    logic [FP16_EXP_W-1:0]  exp;
    logic [FP16_FRAC_W-1:0] frac;
  } fp16_t;

  // Works on value*2 so the lowest kept bit is the half bit; adding one and
  // halving then gives round-half-up. Results reaching 256 saturate.
  function automatic logic [7:0] fp16_to_u8(input fp16_t op, input int lead);
    int          exp_unb;
    logic [31:0] mant;
    logic [31:0] dbl;
    logic [31:0] half;
    logic [7:0]  res;
    exp_unb = int'(op.exp) - FP16_BIAS;
    mant    = {21'd0, 1'b1, op.frac};
    dbl     = 32'd0;
    half    = 32'd0;
    res     = 8'h00;
    if (op.sign) begin
      res = 8'h00;
    end else if (op.exp == 5'h1F || exp_unb > lead) begin
      res = U8_MAX;
    end else if (exp_unb < -1) begin
      res = 8'h00;
    end else begin
      if (exp_unb >= 9) begin
        dbl = mant << (exp_unb - 9);
      end else begin
        dbl = mant >> (9 - exp_unb);
      end
      half = (dbl + 32'd1) >> 1;
      res  = (half > 32'd255) ? U8_MAX : half[7:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/fp16_u8_arbiter_chk.sv
// Protocol checks for fp16_u8_arbiter: no push into a full FIFO, one-hot
// requester ready, converter valid tracks the inflight flag.
module fp16_u8_arbiter_chk #(
  parameter int NUM_REQ   = 4,
  parameter int OUT_DEPTH = 2,
  parameter int CNT_W     = 2
) (
  input logic               clk,
  input logic               rst,
  input logic               push,
  input logic               pop,
  input logic [CNT_W-1:0]   count,
  input logic [NUM_REQ-1:0] req_ready,
  input logic               conv_valid,
  input logic               inflight
);

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    push |-> ((count < CNT_W'(OUT_DEPTH)) || pop));

  a_ready_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0(req_ready));

  a_conv_tracks: assert property (@(posedge clk) disable iff (rst)
    conv_valid == inflight);

endmodule

// File: rtl/fp16_u8_converter.sv
// Single-cycle registered fp16 -> u8 converter: negative -> 0, too large -> 0xFF,
// too small -> 0, round-half-up otherwise. It has no stall input.
module fp16_u8_converter
  import fp16_u8_pkg::*;
#(
  parameter int LEAD_EXPONENT_UNBIASED = 7
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] fp16_i,
  input  logic        valid_i,
  output logic [7:0]  u8_o,
  output logic        valid_o
);

  // Result and valid register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      u8_o    <= 8'h00;
      valid_o <= 1'b0;
    end else begin
      valid_o <= valid_i;
      if (valid_i) begin
        u8_o <= fp16_to_u8(fp16_t'(fp16_i), LEAD_EXPONENT_UNBIASED);
      end
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above the pointer
// (modulo N) and moves the pointer past the winner.
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            en,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id
);

  logic [ID_W-1:0] rr_ptr_r;
  logic            hit_s;
  logic            gnt_any_s;
  int              idx_s;
  int              pick_s;

  // Walk from the far end back to rr_ptr so the nearest valid requester wins last
  always_comb begin
    hit_s  = 1'b0;
    idx_s  = 0;
    pick_s = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx_s  = (int'(rr_ptr_r) + k >= N) ? int'(rr_ptr_r) + k - N : int'(rr_ptr_r) + k;
      pick_s = req[idx_s] ? idx_s : pick_s;
      hit_s  = hit_s | req[idx_s];
    end
    gnt_any_s = en && hit_s;
    gnt_id    = ID_W'(pick_s);
    gnt       = gnt_any_s ? (N'(1) << pick_s) : '0;
  end

  // Pointer advances past the winner; holds when nothing is granted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_r <= '0;
    end else if (gnt_any_s) begin
      rr_ptr_r <= (gnt_id == ID_W'(N - 1)) ? '0 : gnt_id + ID_W'(1);
    end
  end

endmodule

// File: rtl/fp16_u8_arbiter.sv
// Round-robin sharing of one fp16->u8 converter with a credit-checked FWFT
// output FIFO. Define FP16_U8_ARB_STATS_EN to add the sat_count_o counter.
module fp16_u8_arbiter
  import fp16_u8_pkg::*;
#(
  parameter int NUM_REQ                = 4,
  parameter int LEAD_EXPONENT_UNBIASED = 7,
  parameter int OUT_DEPTH              = 2,
  localparam int ID_W                  = $clog2(NUM_REQ)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_REQ*16-1:0] req_fp16_i,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  output logic [7:0]            u8_o,
  output logic [ID_W-1:0]       id_o,
  output logic                  valid_o,
  input  logic                  ready_i
`ifdef FP16_U8_ARB_STATS_EN
  ,
  output logic [15:0]           sat_count_o
`endif
);

  localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CNT_W = $clog2(OUT_DEPTH + 1);

  logic [NUM_REQ-1:0] gnt_s;
  logic [ID_W-1:0]    gnt_id_s;
  logic               issue_s;
  logic               credit_ok_s;
  logic               pop_s;
  logic [CNT_W:0]     used_s;
  logic [15:0]        conv_in_s;
  logic [7:0]         conv_u8_s;
  logic               conv_valid_s;

  logic [ID_W-1:0]    tag_r;
  logic               inflight_r;
  logic [CNT_W-1:0]   count_r;
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [7:0]         mem_u8_r [OUT_DEPTH];
  logic [ID_W-1:0]    mem_id_r [OUT_DEPTH];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Credit: the result already in flight must find a free FIFO slot
  always_comb begin
    pop_s       = (count_r != '0) && ready_i;
    used_s      = (CNT_W+1)'(count_r) + (CNT_W+1)'(inflight_r) - (CNT_W+1)'(pop_s);
    credit_ok_s = (used_s < (CNT_W+1)'(OUT_DEPTH)) && !rst_i;
  end

  rr_arbiter #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_arb (
    .clk    (clk_i),
    .rst    (rst_i),
    .req    (req_valid_i),
    .en     (credit_ok_s),
    .gnt    (gnt_s),
    .gnt_id (gnt_id_s)
  );

  assign issue_s     = |gnt_s;
  assign req_ready_o = gnt_s;
  assign conv_in_s   = req_fp16_i[16*gnt_id_s +: 16];

  fp16_u8_converter #(
    .LEAD_EXPONENT_UNBIASED (LEAD_EXPONENT_UNBIASED)
  ) u_conv (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .fp16_i  (conv_in_s),
    .valid_i (issue_s),
    .u8_o    (conv_u8_s),
    .valid_o (conv_valid_s)
  );

  // Issue tracking: tag and inflight flag for the converter's one-cycle latency
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tag_r      <= '0;
      inflight_r <= 1'b0;
    end else begin
      inflight_r <= issue_s;
      if (issue_s) begin
        tag_r <= gnt_id_s;
      end
    end
  end

  // Circular FWFT FIFO; storage is cleared so the head reads zero after reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int k = 0; k < OUT_DEPTH; k++) begin
        mem_u8_r[k] <= 8'h00;
        mem_id_r[k] <= '0;
      end
    end else begin
      if (inflight_r) begin
        mem_u8_r[wr_ptr_r] <= conv_u8_s;
        mem_id_r[wr_ptr_r] <= tag_r;
        wr_ptr_r           <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      count_r <= count_r + CNT_W'(inflight_r) - CNT_W'(pop_s);
    end
  end

  assign valid_o = (count_r != '0);
  assign u8_o    = mem_u8_r[rd_ptr_r];
  assign id_o    = mem_id_r[rd_ptr_r];

`ifdef FP16_U8_ARB_STATS_EN
  logic [15:0] sat_count_r;

  // Saturating count of 0xFF results entering the FIFO
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sat_count_r <= 16'h0000;
    end else if (inflight_r && conv_u8_s == U8_MAX && sat_count_r != 16'hFFFF) begin
      sat_count_r <= sat_count_r + 16'h0001;
    end
  end

  assign sat_count_o = sat_count_r;
`endif

  fp16_u8_arbiter_chk #(
    .NUM_REQ   (NUM_REQ),
    .OUT_DEPTH (OUT_DEPTH),
    .CNT_W     (CNT_W)
  ) u_chk (
    .clk        (clk_i),
    .rst        (rst_i),
    .push       (inflight_r),
    .pop        (pop_s),
    .count      (count_r),
    .req_ready  (req_ready_o),
    .conv_valid (conv_valid_s),
    .inflight   (inflight_r)
  );

endmodule

// File: doc/fp16_u8_arbiter.md
# fp16_u8_arbiter

- Shares one `fp16_u8_converter` datapath between `NUM_REQ` independent fp16 producers using round-robin arbitration.
- Each converted u8 result returns on a single valid/ready output stream, tagged with the source requester ID.
- A credit-checked output FIFO absorbs backpressure, because the converter itself cannot stall.
- Sits between per-channel fp16 pipelines and the 8-bit pixel/packing stage.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `LEAD_EXPONENT_UNBIASED`, 7: forwarded unchanged to the converter.
- `OUT_DEPTH`, 2: output FIFO entries, ≥2.
- `ID_W`, `$clog2(NUM_REQ)`: tag width (local).
- `clk_i` in 1: single clock; all logic in this domain.
- `rst_i` in 1: reset, asynchronous, active-high.
- `req_fp16_i` in `NUM_REQ*16`: requester i's operand in bits [16i+15:16i].
- `req_valid_i` in `NUM_REQ`: per-requester valid.
- `req_ready_o` out `NUM_REQ`: per-requester ready; at most one bit set per cycle.
- `u8_o` out 8: converted result (FIFO head).
- `id_o` out `ID_W`: requester index that produced `u8_o`.
- `valid_o` out 1: FIFO head valid.
- `ready_i` in 1: downstream accept.

## Operation
- Handshake: a transfer occurs when `valid && ready`. `req_ready_o[i]` may depend combinationally on `req_valid_i`. Producers must hold data and valid until the transfer completes.
- Credit:
  - `used = fifo_count + inflight - (valid_o && ready_i)`; `inflight` is 0 or 1.
  - An issue is allowed only when `used < OUT_DEPTH`. If not allowed, all `req_ready_o` are 0.
- Arbitration:
  - Registered pointer `rr_ptr`.
  - The grant goes to the first i with `req_valid_i[i]` set, searching from `rr_ptr` upward modulo `NUM_REQ`.
  - On a grant, `rr_ptr <= (granted + 1) mod NUM_REQ`. With no grant, `rr_ptr` holds.
- Issue: the granted operand and a converter valid of 1 drive the converter. `tag_q <= granted ID` and `inflight <= 1`; otherwise `inflight <= 0`.
- Completion: when `inflight` is 1, the cycle after issue, the converter's `u8_o` and `tag_q` are pushed into the FIFO. The credit check guarantees the FIFO is never full on a push. No overflow detection is required beyond an assertion.
- FIFO:
  - First-word-fall-through, circular, with wrap-around read and write pointers.
  - Push and pop in the same cycle are legal at any occupancy, including when empty: the push goes to storage and `valid_o` rises next cycle.
- The converter's own valid output is ignored; `inflight` is authoritative. The converter receives `rst_i` unchanged.
- Result semantics are exactly the converter's: negative → 0, exponent above range → 0xFF, below range → 0, round-half-up.

## Timing
- Latency: operand accepted at cycle T → result on `u8_o` with `valid_o=1` at T+2.
- Throughput: one result per cycle sustained when `ready_i` is held high (`OUT_DEPTH`≥2).
- Fairness: with all requesters valid, grants rotate 0,1,…,N-1,0. Each continuously valid requester is served within `NUM_REQ` issue slots.
- Reset values (asynchronous, immediate):
  - `valid_o`=0, `u8_o`=0, `id_o`=0.
  - `req_ready_o`=0 while `rst_i` is high.
  - `rr_ptr`=0, `inflight`=0, FIFO empty.
- Mid-operation reset: the in-flight result and all FIFO contents are discarded. The first grant after deassertion goes to the lowest-index valid requester at or after 0.
- Downstream stall: with `ready_i`=0, at most `OUT_DEPTH` results are accepted, then all `req_ready_o` drop. `u8_o`/`id_o` hold stable while `valid_o && !ready_i`.

## Configuration
- Macro: `FP16_U8_ARB_STATS_EN`.
- Defined: adds output `sat_count_o [15:0]`, which counts results pushed with value 0xFF from non-negative inputs. It saturates at 0xFFFF and resets to 0.
- Undefined: the port and counter do not exist. All other behaviour is identical.

## Structure
- Package `fp16_u8_pkg`:
  - `fp16_t` (16-bit packed: sign, exp[4:0], frac[9:0]).
  - `FP16_EXP_W`=5, `FP16_FRAC_W`=10, `U8_MAX`=8'hFF.
- Sub-module `rr_arbiter` (parameter `N`): request vector plus enable in, one-hot grant plus encoded ID out, owns `rr_ptr`.
- The converter instance, credit logic and FIFO live in the top.

## Test plan
- Single request: requester 2 sends 0x3C00 (1.0) → `u8_o`=0x01, `id_o`=2 at T+2.
- All 4 requesters valid continuously with `ready_i`=1:
  - Operands 0x4000, 0x3800, 0xBC00, 0x7BFF on requesters 0-3.
  - Expect per-cycle IDs 0,1,2,3,0… with results 0x02, 0x01, 0x00, 0xFF.
  - Expect no bubbles after the first result.
- Backpressure: `ready_i`=0 with all requesters valid → exactly 2 accepts, then `req_ready_o`=0. Raise `ready_i` → results drain in order with no loss or duplication.
- Simultaneous push/pop with FIFO at 1 entry and `ready_i` toggling every cycle → output order matches accept order across pointer wrap.
- Reset asserted while `inflight`=1 and FIFO holding 1 entry → `valid_o`=0 immediately. The first post-reset result belongs to the first post-reset accept.
- With `FP16_U8_ARB_STATS_EN`: send 0x7BFF three times and 0xBC00 once → `sat_count_o`=3.
